fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V pipeline. It produces the instruction stream that the decode controller consumes: the op, f3 and f7 fields plus the full instruction and its PC. It owns the PC and issues word reads to instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO toward decode, and the FIFO is flushed on control-flow redirects resolved in execute (jal, jalr, taken branch).

---
 rtl/rv_pkg.sv | 43 ++++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, instruction field slices, fetch FSM state, fetch entry.
package rv_pkg;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_ARITH = 7'b0010011;
  localparam logic [6:0] LW      = 7'b0000011;
  localparam logic [6:0] SW      = 7'b0100011;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] LUI     = 7'b0110111;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [6:0] instr_op(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [2:0] instr_f3(input logic [31:0] instr);
    return instr[F3_MSB:F3_LSB];
  endfunction

  function automatic logic [6:0] instr_f7(input logic [31:0] instr);
    return instr[F7_MSB:F7_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory req/ack, execute redirect, and the valid/ready stream toward decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_op;
  logic [2:0]  id_f3;
  logic [6:0]  id_f7;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_op, id_f3, id_f7,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_op, id_f3, id_f7,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// First-word fall-through {pc, instr} FIFO; a push is visible on dout the next cycle.
// Flush empties it on the next edge and wins over a same-cycle push/pop; DEPTH must be a power of two.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic         valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop & valid;
  // Empty slots read as zero so decode never sees a stale or uninitialised word.
  assign dout   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem read at a time and queues results toward decode.
// A request starts only with a free FIFO slot reserved, so acks are never dropped; redirects kill in-flight reads.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t  state, state_n;
  logic [31:0]   pc, pc_n;
  logic [31:0]   req_addr, req_addr_n;
  logic [31:0]   redir_tgt;
  logic          push;
  logic          pop;
  logic          fifo_valid;
  logic [CW-1:0] count;
  logic          room_now;
  logic          room_after;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redir_tgt  = {bus.redirect_pc[31:2], 2'b00};
  assign pop        = fifo_valid & bus.id_ready;
  assign room_now   = 32'(count) < DEPTH;
  // Room for another request once this ack lands, counting a same-cycle pop.
  assign room_after = (32'(count) + 32'd1 - 32'(pop)) < DEPTH;
  assign push_entry = '{pc: req_addr, instr: bus.imem_rdata};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.redirect_valid) begin
          pc_n = redir_tgt;
        end else if (room_now) begin
          req_addr_n = pc;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect_valid) begin
            pc_n    = redir_tgt;
            state_n = IDLE;
          end else begin
            push = 1'b1;
            pc_n = req_addr + 32'd4;
            if (room_after) begin
              req_addr_n = req_addr + 32'd4;
            end else begin
              state_n = IDLE;
            end
          end
        end else if (bus.redirect_valid) begin
          pc_n    = redir_tgt;
          state_n = KILL;
        end
      end
      KILL: begin
        if (bus.redirect_valid) begin
          pc_n = redir_tgt;
        end
        if (bus.imem_ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .valid (fifo_valid),
    .count (count)
  );

  assign bus.imem_req  = (state == REQ) || (state == KILL);
  assign bus.imem_addr = req_addr;
  assign bus.id_valid  = fifo_valid;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc     = head.pc;
  assign bus.id_op     = instr_op(head.instr);
  assign bus.id_f3     = instr_f3(head.instr);
  assign bus.id_f7     = instr_f7(head.instr);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a PC-stream / occupancy reference model.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  bit lat_rand = 1'b0;
  int wait_cyc = 0;

  // Memory returns addr ^ KEY after `lat` waiting cycles; garbage on rdata otherwise.
  task automatic mem_respond();
    if (bus.imem_req === 1'b1 && wait_cyc >= lat) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = bus.imem_addr ^ KEY;
      wait_cyc       = 0;
      if (lat_rand) lat = $urandom_range(0, 3);
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      if (bus.imem_req === 1'b1) wait_cyc++;
    end
  endtask

  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    bus.id_ready       = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    mem_respond();
    #1;
  endtask

  task automatic do_reset(input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    wait_cyc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_instr: got %h want 0", bus.id_instr); end
    checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] e_pc, e_in;
    lat_rand = 1'b0; lat = 0;
    do_reset(1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (k < 4) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_ack !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin
          failures++; $display("FAIL stream_addr k=%0d: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req, bus.imem_addr, 32'(4 * k));
        end
      end
      if (k >= 1 && k <= 4) begin
        e_pc = 32'(4 * (k - 1));
        e_in = e_pc ^ KEY;
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== e_pc || bus.id_instr !== e_in) begin
          failures++; $display("FAIL stream_id k=%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, bus.id_valid, bus.id_pc, bus.id_instr, e_pc, e_in);
        end
        checks++;
        if (bus.id_op !== e_in[6:0] || bus.id_f3 !== e_in[14:12] || bus.id_f7 !== e_in[31:25]) begin
          failures++; $display("FAIL stream_fields k=%0d: got op=%h f3=%h f7=%h want op=%h f3=%h f7=%h", k, bus.id_op, bus.id_f3, bus.id_f7, e_in[6:0], e_in[14:12], e_in[31:25]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acks, npop;
    logic [31:0] pops [2];
    logic [31:0] first_ack;
    bit got_ack;
    lat_rand = 1'b0; lat = 1;
    do_reset(1'b0, 32'h0);
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) acks++;
      if (bus.id_valid === 1'b1) begin
        checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL bp_hold k=%0d: got pc=%h want 0", k, bus.id_pc); end
      end
    end
    checks++; if (acks != 2) begin failures++; $display("FAIL bp_acks: got %0d want 2", acks); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle: got %b want 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", bus.id_valid, bus.id_pc); end
    npop = 0; got_ack = 1'b0; first_ack = '0; pops[0] = '1; pops[1] = '1;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (bus.id_valid === 1'b1 && npop < 2) begin pops[npop] = bus.id_pc; npop++; end
      if (!got_ack && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin got_ack = 1'b1; first_ack = bus.imem_addr; end
    end
    checks++; if (pops[0] !== 32'h0 || pops[1] !== 32'h4) begin failures++; $display("FAIL bp_drain: got %h,%h want 0,4", pops[0], pops[1]); end
    checks++; if (!got_ack || first_ack !== 32'h8) begin failures++; $display("FAIL bp_resume: got ack=%b addr=%h want ack=1 addr=8", got_ack, first_ack); end
  endtask

  task automatic test_redirect_kill();
    bit seen10, got_ack, got_pc;
    logic [31:0] first_ack, first_pc, first_in;
    lat_rand = 1'b0; lat = 3;
    do_reset(1'b1, 32'h10);
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL kill_idle_after_redirect: got req=%b want 0", bus.imem_req); end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, k == 1, 32'h100);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.id_valid !== 1'b0) begin
        failures++; $display("FAIL kill_hold k=%0d: got req=%b addr=%h idv=%b want req=1 addr=10 idv=0", k, bus.imem_req, bus.imem_addr, bus.id_valid);
      end
    end
    checks++; if (bus.imem_ack !== 1'b1) begin failures++; $display("FAIL kill_ack_timing: got ack=%b want 1", bus.imem_ack); end
    seen10 = 1'b0; got_ack = 1'b0; got_pc = 1'b0; first_ack = '0; first_pc = '0; first_in = '0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (bus.id_valid === 1'b1 && bus.id_pc === 32'h10) seen10 = 1'b1;
      if (!got_ack && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin got_ack = 1'b1; first_ack = bus.imem_addr; end
      if (!got_pc && bus.id_valid === 1'b1) begin got_pc = 1'b1; first_pc = bus.id_pc; first_in = bus.id_instr; end
    end
    checks++; if (seen10) begin failures++; $display("FAIL kill_stale: got killed pc 10 presented want never"); end
    checks++; if (!got_ack || first_ack !== 32'h100) begin failures++; $display("FAIL kill_next_addr: got ack=%b addr=%h want 100", got_ack, first_ack); end
    checks++; if (!got_pc || first_pc !== 32'h100 || first_in !== (32'h100 ^ KEY)) begin
      failures++; $display("FAIL kill_first_pc: got v=%b pc=%h instr=%h want pc=100 instr=%h", got_pc, first_pc, first_in, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_flush_collision();
    bit got_ack, got_pc;
    logic [31:0] first_ack, first_pc;
    lat_rand = 1'b0; lat = 0;
    do_reset(1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h200);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.imem_ack !== 1'b1) begin
      failures++; $display("FAIL coll_setup: got v=%b pc=%h ack=%b want v=1 pc=0 ack=1", bus.id_valid, bus.id_pc, bus.imem_ack);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL coll_flush: got id_valid=%b pc=%h want 0", bus.id_valid, bus.id_pc); end
    got_ack = 1'b0; got_pc = 1'b0; first_ack = '0; first_pc = '0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (!got_ack && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin got_ack = 1'b1; first_ack = bus.imem_addr; end
      if (!got_pc && bus.id_valid === 1'b1) begin got_pc = 1'b1; first_pc = bus.id_pc; end
    end
    checks++; if (!got_ack || first_ack !== 32'h200) begin failures++; $display("FAIL coll_next_addr: got ack=%b addr=%h want 200", got_ack, first_ack); end
    checks++; if (!got_pc || first_pc !== 32'h200) begin failures++; $display("FAIL coll_first_pc: got v=%b pc=%h want 200", got_pc, first_pc); end
  endtask

  task automatic test_wrap();
    int na, np;
    logic [31:0] a [2];
    logic [31:0] p [2];
    bit got_ack, got_pc;
    logic [31:0] first_ack, first_pc;
    lat_rand = 1'b0; lat = 0;
    do_reset(1'b1, 32'hFFFF_FFFF);
    na = 0; np = 0; a[0] = '1; a[1] = '1; p[0] = '1; p[1] = '1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (bus.imem_req === 1'b1 && bus.imem_ack === 1'b1 && na < 2) begin a[na] = bus.imem_addr; na++; end
      if (bus.id_valid === 1'b1 && np < 2) begin p[np] = bus.id_pc; np++; end
    end
    checks++; if (a[0] !== 32'hFFFF_FFFC || a[1] !== 32'h0) begin failures++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", a[0], a[1]); end
    checks++; if (p[0] !== 32'hFFFF_FFFC || p[1] !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h,%h want fffffffc,00000000", p[0], p[1]); end
    cycle(1'b1, 1'b1, 32'h103);
    got_ack = 1'b0; got_pc = 1'b0; first_ack = '0; first_pc = '0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (!got_ack && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin got_ack = 1'b1; first_ack = bus.imem_addr; end
      if (!got_pc && bus.id_valid === 1'b1) begin got_pc = 1'b1; first_pc = bus.id_pc; end
    end
    checks++; if (!got_ack || first_ack !== 32'h100) begin failures++; $display("FAIL align_addr: got ack=%b addr=%h want 100", got_ack, first_ack); end
    checks++; if (!got_pc || first_pc !== 32'h100) begin failures++; $display("FAIL align_pc: got v=%b pc=%h want 100", got_pc, first_pc); end
  endtask

  task automatic test_async_reset();
    lat_rand = 1'b0; lat = 2;
    do_reset(1'b0, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b1 || bus.id_valid !== 1'b1) begin
      failures++; $display("FAIL arst_setup: got req=%b idv=%b want 1,1", bus.imem_req, bus.id_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL arst_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0) begin failures++; $display("FAIL arst_id: got v=%b pc=%h want 0,0", bus.id_valid, bus.id_pc); end
    wait_cyc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++; $display("FAIL arst_restart: got req=%b addr=%h want 1,0", bus.imem_req, bus.imem_addr);
    end
  endtask

  // Reference model: expected fetch address, expected next popped PC, occupancy, kill flag.
  task automatic test_random();
    logic [31:0] fpc, exp_pc, exp_in, tgt, prev_addr, t_al;
    int occ, pops;
    bit killed, prev_req, prev_ack, rdy, redir, req, ack, pop, kept;
    lat_rand = 1'b1; lat = 0;
    do_reset(1'b0, 32'h0);
    fpc = 32'h0; exp_pc = 32'h0; occ = 0; pops = 0;
    killed = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      cycle(rdy, redir, tgt);
      req = (bus.imem_req === 1'b1);
      ack = (bus.imem_ack === 1'b1);
      if (prev_req && !prev_ack) begin
        checks++;
        if (!req || bus.imem_addr !== prev_addr) begin
          failures++; $display("FAIL rnd_stable n=%0d: got req=%b addr=%h want req=1 addr=%h", n, req, bus.imem_addr, prev_addr);
        end
      end
      if (req && !killed) begin
        checks++;
        if (bus.imem_addr !== fpc) begin failures++; $display("FAIL rnd_fetch_addr n=%0d: got %h want %h", n, bus.imem_addr, fpc); end
      end
      checks++;
      if (bus.id_valid !== (occ != 0)) begin failures++; $display("FAIL rnd_id_valid n=%0d: got %b want %b", n, bus.id_valid, occ != 0); end
      if (occ != 0) begin
        exp_in = exp_pc ^ KEY;
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== exp_in || bus.id_op !== exp_in[6:0] ||
            bus.id_f3 !== exp_in[14:12] || bus.id_f7 !== exp_in[31:25]) begin
          failures++; $display("FAIL rnd_head n=%0d: got pc=%h instr=%h want pc=%h instr=%h", n, bus.id_pc, bus.id_instr, exp_pc, exp_in);
        end
      end
      pop  = (occ != 0) && rdy;
      kept = req && ack && !killed && !redir;
      if (pop && !redir) pops++;
      if (redir) begin
        t_al   = {tgt[31:2], 2'b00};
        occ    = 0;
        exp_pc = t_al;
        fpc    = t_al;
      end else begin
        occ = occ + int'(kept) - int'(pop);
        if (pop)  exp_pc = exp_pc + 32'd4;
        if (kept) fpc    = fpc + 32'd4;
      end
      if (req && ack) killed = 1'b0;
      else if (req && redir) killed = 1'b1;
      prev_req = req; prev_ack = ack; prev_addr = bus.imem_addr;
    end
    checks++; if (pops < 300) begin failures++; $display("FAIL rnd_progress: got %0d pops want >= 300", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_kill();
    test_flush_collision();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
